// File: rtl/trig_pkg.sv
// Shared constants, command opcodes and FSM state encodings for the
// trigger-board histogram readout path.
package trig_pkg;

    localparam int unsigned NHIST       = 8;
    localparam int unsigned NCH         = 16;
    localparam int unsigned HW          = 32;
    localparam int unsigned SETTLE      = 2;
    localparam int unsigned CLR_CYC     = 4;
    localparam int unsigned CHW         = 4;
    localparam int unsigned SELW        = 8;
    localparam int unsigned CNTW        = 3;
    localparam int unsigned FRAME_BYTES = 2 + NHIST * HW / 8;
    localparam int unsigned FRAMEW      = FRAME_BYTES * 8;
    localparam int unsigned IDXW        = 6;
    localparam int unsigned FIDXW       = 9;

    localparam logic [7:0] FRAME_SYNC = 8'hA5;

    typedef enum logic [1:0] {
        OP_DUMP_ALL = 2'd0,
        OP_DUMP_ONE = 2'd1,
        OP_CLEAR    = 2'd2,
        OP_RSVD     = 2'd3
    } cmd_op_e;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SELECT = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_LATCH  = 3'd3;
    localparam logic [2:0] S_SEND   = 3'd4;
    localparam logic [2:0] S_NEXT   = 3'd5;
    localparam logic [2:0] S_CLEAR  = 3'd6;
    localparam logic [2:0] S_DONE   = 3'd7;

endpackage

// File: rtl/frame_serializer.sv
// Walks one frame (sync, channel, little-endian shadow words) byte by byte
// over a valid/ready stream; holds data stable while the sink stalls.
module frame_serializer
    import trig_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start_i,
    input  logic [NHIST*HW-1:0]   words_i,
    input  logic [CHW-1:0]        chan_i,
    input  logic                  tx_ready_i,
    output logic [7:0]            tx_data_o,
    output logic                  tx_valid_o,
    output logic                  last_acc_c
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_BYTES - 1);

    logic [IDXW-1:0]   idx_q, idx_d, next_idx_c;
    logic [7:0]        data_q, data_d;
    logic              valid_q, valid_d;
    logic [FRAMEW-1:0] frame_c;

    // Byte i of the frame lives at bits [i*8 +: 8].
    assign frame_c    = {words_i, {(8 - CHW){1'b0}}, chan_i, FRAME_SYNC};
    assign next_idx_c = idx_q + IDXW'(1);
    assign last_acc_c = valid_q && tx_ready_i && (idx_q == LAST_IDX);

    always_comb begin
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        if (start_i) begin
            idx_d   = '0;
            data_d  = FRAME_SYNC;
            valid_d = 1'b1;
        end else if (valid_q && tx_ready_i) begin
            if (idx_q == LAST_IDX) begin
                valid_d = 1'b0;
            end else begin
                idx_d  = next_idx_c;
                data_d = frame_c[{next_idx_c, 3'b000} +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign tx_data_o  = data_q;
    assign tx_valid_o = valid_q;

endmodule

// File: rtl/histo_readout_ctrl.sv
// Command-driven scheduler: steps histogram select lines, latches the bin
// words into a shadow register, streams framed bytes, and sequences clears.
module histo_readout_ctrl
    import trig_pkg::*;
(
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [CHW-1:0]        cmd_chan,
    output logic [SELW-1:0]       hist_sel,
    input  logic [NHIST*HW-1:0]   histos_in,
    output logic                  resethist,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  busy,
    output logic                  done
);

    logic [2:0]          state_q, state_d;
    cmd_op_e             op_q, op_d;
    logic [CHW-1:0]      chan_q, chan_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [SELW-1:0]     hist_sel_q, hist_sel_d;
    logic [NHIST*HW-1:0] shadow_q, shadow_d;
    logic                cmd_ready_q, busy_q, resethist_q, done_q;
    logic                start_c, last_acc_c;

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        hist_sel_d = hist_sel_q;
        shadow_d   = shadow_q;
        start_c    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d   = cmd_op_e'(cmd_op);
                    chan_d = (cmd_op_e'(cmd_op) == OP_DUMP_ONE) ? cmd_chan : '0;
                    cnt_d  = '0;
                    case (cmd_op_e'(cmd_op))
                        OP_DUMP_ALL, OP_DUMP_ONE: state_d = S_SELECT;
                        OP_CLEAR:                 state_d = S_CLEAR;
                        default:                  state_d = S_DONE;
                    endcase
                end
            end
            S_SELECT: begin
                hist_sel_d = SELW'(chan_q);
                cnt_d      = '0;
                state_d    = S_SETTLE;
            end
            S_SETTLE: begin
                if (cnt_q == CNTW'(SETTLE - 1)) state_d = S_LATCH;
                else                            cnt_d   = cnt_q + CNTW'(1);
            end
            S_LATCH: begin
                shadow_d = histos_in;
                start_c  = 1'b1;
                state_d  = S_SEND;
            end
            S_SEND: begin
                if (last_acc_c) state_d = S_NEXT;
            end
            S_NEXT: begin
                // Dump-all stops on the last channel by compare, never by wrap.
                if (op_q == OP_DUMP_ALL && chan_q != CHW'(NCH - 1)) begin
                    chan_d  = chan_q + CHW'(1);
                    state_d = S_SELECT;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_CLEAR: begin
                if (cnt_q == CNTW'(CLR_CYC - 1)) state_d = S_DONE;
                else                             cnt_d   = cnt_q + CNTW'(1);
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            op_q        <= OP_DUMP_ALL;
            chan_q      <= '0;
            cnt_q       <= '0;
            hist_sel_q  <= '0;
            shadow_q    <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            resethist_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            chan_q      <= chan_d;
            cnt_q       <= cnt_d;
            hist_sel_q  <= hist_sel_d;
            shadow_q    <= shadow_d;
            cmd_ready_q <= (state_d == S_IDLE);
            busy_q      <= (state_d != S_IDLE);
            resethist_q <= (state_d == S_CLEAR);
            done_q      <= (state_q == S_DONE);
        end
    end

    frame_serializer u_ser (
        .clk        (clk),
        .nrst       (nrst),
        .start_i    (start_c),
        .words_i    (shadow_q),
        .chan_i     (chan_q),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .last_acc_c (last_acc_c)
    );

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign resethist = resethist_q;
    assign done      = done_q;
    assign hist_sel  = hist_sel_q;

endmodule

// File: tb/tb_histo_readout_ctrl.sv
// Directed bench for histo_readout_ctrl: frame contents, latency, stalls,
// clears, reserved op, shadow latching and mid-frame reset.
module tb_histo_readout_ctrl;

    logic         clk = 1'b0;
    logic         nrst;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [3:0]   cmd_chan;
    logic [7:0]   hist_sel;
    logic [255:0] histos_in;
    logic         resethist;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         done;

    int n_vec = 0;
    int n_err = 0;

    histo_readout_ctrl dut (
        .clk       (clk),
        .nrst      (nrst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_chan  (cmd_chan),
        .hist_sel  (hist_sel),
        .histos_in (histos_in),
        .resethist (resethist),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Histogram source: static table or a function of the select lines.
    logic        dyn_mode = 1'b0;
    logic [31:0] st_w [8];
    logic [31:0] exp_w [8];

    function automatic logic [31:0] dyn_word(input int c, input int k);
        return 32'hC000_0000 + 32'(c << 16) + 32'(k << 8) + 32'(c * 8 + k);
    endfunction

    always_comb begin
        for (int k = 0; k < 8; k++)
            histos_in[k*32 +: 32] = dyn_mode ? dyn_word(int'(hist_sel[3:0]), k) : st_w[k];
    end

    function automatic logic [7:0] exp_byte(input int ch, input int i);
        logic [31:0] tmp;
        if (i == 0) return 8'hA5;
        if (i == 1) return 8'(ch);
        tmp = exp_w[(i - 2) / 4] >> (8 * ((i - 2) % 4));
        return tmp[7:0];
    endfunction

    // Ready pattern generator: mode 0 always ready, mode 1 one on / two off.
    int rdy_mode = 0;
    int rdy_ph   = 0;
    always @(posedge clk) begin
        #1;
        if (rdy_mode == 1) begin
            tx_ready = (rdy_ph == 0);
            rdy_ph   = (rdy_ph == 2) ? 0 : rdy_ph + 1;
        end else begin
            tx_ready = 1'b1;
        end
    end

    // Observation log, sampled mid-cycle.
    int          ncyc = 0;
    int          acc_cyc = 0, first_v = -1, last_hs = -1;
    int          ndone = 0, done_cyc = -1;
    int          nrh = 0, rh_first = -1, rh_last = -1;
    int          nvalid = 0, nstall = 0, stall_err = 0;
    logic [7:0]  rx_q [$];
    logic [7:0]  sel_hist [$];
    logic [7:0]  last_sel = 8'd0;
    logic        stall_prev = 1'b0;
    logic [7:0]  prev_data = 8'd0;

    always @(negedge clk) begin
        ncyc++;
        if (cmd_valid && cmd_ready) begin
            acc_cyc = ncyc;
            first_v = -1;
        end
        if (tx_valid && first_v < 0) first_v = ncyc;
        if (tx_valid) nvalid++;
        if (tx_valid && tx_ready) begin
            rx_q.push_back(tx_data);
            last_hs = ncyc;
        end
        if (done) begin
            ndone++;
            done_cyc = ncyc;
        end
        if (resethist) begin
            if (rh_first < 0) rh_first = ncyc;
            rh_last = ncyc;
            nrh++;
        end
        if (stall_prev && nrst) begin
            nstall++;
            if (!(tx_valid && tx_data == prev_data)) stall_err++;
        end
        stall_prev = nrst && tx_valid && !tx_ready;
        prev_data  = tx_data;
        if (hist_sel != last_sel) sel_hist.push_back(hist_sel);
        last_sel = hist_sel;
    end

    task automatic clear_log();
        rx_q.delete();
        sel_hist.delete();
        last_sel  = hist_sel;
        ndone     = 0;
        done_cyc  = -1;
        nrh       = 0;
        rh_first  = -1;
        rh_last   = -1;
        nvalid    = 0;
        nstall    = 0;
        stall_err = 0;
        first_v   = -1;
        last_hs   = -1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [3:0] ch);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_chan  = ch;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc && !ok; i++) begin
            @(posedge clk);
            #1;
            if (ndone > 0) ok = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic set_static(input logic [31:0] base);
        for (int k = 0; k < 8; k++) begin
            st_w[k]  = base + 32'(k);
            exp_w[k] = base + 32'(k);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        cmd_valid = 1'b0;
        cmd_op = 2'd0;
        cmd_chan = 4'd0;
        set_static(32'h0);
        repeat (3) @(posedge clk);
        #1;
        n_vec += 7;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready got %0b want 1", cmd_ready); end
        if (hist_sel !== 8'd0) begin n_err++; $display("FAIL rst_hist_sel got %h want 00", hist_sel); end
        if (resethist !== 1'b0) begin n_err++; $display("FAIL rst_resethist got %0b want 0", resethist); end
        if (tx_data !== 8'd0) begin n_err++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL rst_tx_valid got %0b want 0", tx_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy got %0b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL rst_done got %0b want 0", done); end
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_dump_one();
        bit ok;
        logic [7:0] hand [10] = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00,
                                  8'h05, 8'h01, 8'h00, 8'h00, 8'h05};
        set_static(32'h0500_0000);
        clear_log();
        issue(2'd1, 4'd5);
        wait_done(200, ok);
        n_vec++;
        if (!ok) begin n_err++; $display("FAIL one_timeout done never seen"); end
        n_vec++;
        if (rx_q.size() != 34) begin n_err++; $display("FAIL one_len got %0d want 34", rx_q.size()); end
        for (int i = 0; i < 10 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== hand[i]) begin n_err++; $display("FAIL one_byte%0d got %h want %h", i, rx_q[i], hand[i]); end
        end
        for (int i = 10; i < 34 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_byte(5, i)) begin n_err++; $display("FAIL one_byte%0d got %h want %h", i, rx_q[i], exp_byte(5, i)); end
        end
        n_vec += 4;
        if (first_v - acc_cyc != 5) begin n_err++; $display("FAIL one_latency got %0d want 5", first_v - acc_cyc); end
        if (last_hs - first_v + 1 != 34) begin n_err++; $display("FAIL one_bubbles span %0d want 34", last_hs - first_v + 1); end
        if (ndone != 1) begin n_err++; $display("FAIL one_done_count got %0d want 1", ndone); end
        if (hist_sel !== 8'd5) begin n_err++; $display("FAIL one_hist_sel got %h want 05", hist_sel); end
    endtask

    task automatic test_dump_all();
        bit ok;
        int bad;
        dyn_mode = 1'b1;
        clear_log();
        issue(2'd0, 4'd0);
        wait_done(2000, ok);
        n_vec += 4;
        if (!ok) begin n_err++; $display("FAIL all_timeout done never seen"); end
        if (rx_q.size() != 544) begin n_err++; $display("FAIL all_len got %0d want 544", rx_q.size()); end
        if (ndone != 1) begin n_err++; $display("FAIL all_done_count got %0d want 1", ndone); end
        if (sel_hist.size() != 16) begin n_err++; $display("FAIL all_sel_steps got %0d want 16", sel_hist.size()); end
        for (int n = 0; n < 16 && n < sel_hist.size(); n++) begin
            n_vec++;
            if (sel_hist[n] !== 8'(n)) begin n_err++; $display("FAIL all_sel%0d got %h want %h", n, sel_hist[n], 8'(n)); end
        end
        for (int n = 0; n < 16 && rx_q.size() == 544; n++) begin
            for (int k = 0; k < 8; k++) exp_w[k] = dyn_word(n, k);
            n_vec++;
            if (rx_q[n*34 + 1] !== 8'(n)) begin n_err++; $display("FAIL all_chan%0d got %h want %h", n, rx_q[n*34 + 1], 8'(n)); end
            bad = -1;
            for (int i = 33; i >= 0; i--)
                if (rx_q[n*34 + i] !== exp_byte(n, i)) bad = i;
            n_vec++;
            if (bad >= 0) begin n_err++; $display("FAIL all_frame%0d byte%0d got %h want %h", n, bad, rx_q[n*34 + bad], exp_byte(n, bad)); end
        end
        dyn_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        set_static(32'h0500_0000);
        rdy_mode = 1;
        clear_log();
        issue(2'd1, 4'd5);
        wait_done(400, ok);
        rdy_mode = 0;
        n_vec += 4;
        if (!ok) begin n_err++; $display("FAIL bp_timeout done never seen"); end
        if (rx_q.size() != 34) begin n_err++; $display("FAIL bp_len got %0d want 34", rx_q.size()); end
        if (nstall == 0) begin n_err++; $display("FAIL bp_no_stall got %0d stalls want >0", nstall); end
        if (stall_err != 0) begin n_err++; $display("FAIL bp_stable got %0d unstable stalls want 0", stall_err); end
        for (int i = 0; i < 34 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_byte(5, i)) begin n_err++; $display("FAIL bp_byte%0d got %h want %h", i, rx_q[i], exp_byte(5, i)); end
        end
    endtask

    task automatic test_clear();
        bit ok;
        clear_log();
        issue(2'd2, 4'd0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_op    = 2'd1;
        cmd_chan  = 4'd7;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_done(50, ok);
        repeat (20) @(posedge clk);
        #1;
        n_vec += 7;
        if (!ok) begin n_err++; $display("FAIL clr_timeout done never seen"); end
        if (nrh != 4) begin n_err++; $display("FAIL clr_width got %0d want 4", nrh); end
        if (rh_last - rh_first + 1 != 4) begin n_err++; $display("FAIL clr_consecutive span %0d want 4", rh_last - rh_first + 1); end
        if (rh_first - acc_cyc != 1) begin n_err++; $display("FAIL clr_start got %0d want 1", rh_first - acc_cyc); end
        if (nvalid != 0) begin n_err++; $display("FAIL clr_tx_valid got %0d want 0", nvalid); end
        if (ndone != 1) begin n_err++; $display("FAIL clr_done_count got %0d want 1", ndone); end
        if (done_cyc - acc_cyc != 6) begin n_err++; $display("FAIL clr_done_time got %0d want 6", done_cyc - acc_cyc); end
    endtask

    task automatic test_reserved();
        bit ok;
        clear_log();
        issue(2'd3, 4'd0);
        wait_done(20, ok);
        n_vec += 5;
        if (!ok) begin n_err++; $display("FAIL rsv_timeout done never seen"); end
        if (done_cyc - acc_cyc != 2) begin n_err++; $display("FAIL rsv_done_time got %0d want 2", done_cyc - acc_cyc); end
        if (nvalid != 0) begin n_err++; $display("FAIL rsv_tx_valid got %0d want 0", nvalid); end
        if (nrh != 0) begin n_err++; $display("FAIL rsv_resethist got %0d want 0", nrh); end
        if (ndone != 1) begin n_err++; $display("FAIL rsv_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_latch_hold();
        bit ok, seen;
        set_static(32'h0200_0000);
        clear_log();
        issue(2'd1, 4'd2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (tx_valid) seen = 1'b1;
        end
        for (int k = 0; k < 8; k++) st_w[k] = 32'hDEAD_BEEF;
        wait_done(100, ok);
        n_vec += 3;
        if (!seen) begin n_err++; $display("FAIL latch_no_valid tx_valid never rose"); end
        if (!ok) begin n_err++; $display("FAIL latch_timeout done never seen"); end
        if (rx_q.size() != 34) begin n_err++; $display("FAIL latch_len got %0d want 34", rx_q.size()); end
        for (int i = 2; i < 34 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_byte(2, i)) begin n_err++; $display("FAIL latch_byte%0d got %h want %h", i, rx_q[i], exp_byte(2, i)); end
        end
    endtask

    task automatic test_reset_midframe();
        bit ok, hit;
        dyn_mode = 1'b1;
        clear_log();
        issue(2'd0, 4'd0);
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(posedge clk);
            #1;
            if (rx_q.size() == 3 * 34 + 10) hit = 1'b1;
        end
        n_vec += 3;
        if (!hit) begin n_err++; $display("FAIL mid_reach byte count got %0d want 112", rx_q.size()); end
        if (hist_sel !== 8'd3) begin n_err++; $display("FAIL mid_sel got %h want 03", hist_sel); end
        if (tx_valid !== 1'b1) begin n_err++; $display("FAIL mid_valid got %0b want 1", tx_valid); end
        #1;
        nrst = 1'b0;
        #1;
        n_vec += 7;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_cmd_ready got %0b want 1", cmd_ready); end
        if (hist_sel !== 8'd0) begin n_err++; $display("FAIL mid_hist_sel got %h want 00", hist_sel); end
        if (resethist !== 1'b0) begin n_err++; $display("FAIL mid_resethist got %0b want 0", resethist); end
        if (tx_data !== 8'd0) begin n_err++; $display("FAIL mid_tx_data got %h want 00", tx_data); end
        if (tx_valid !== 1'b0) begin n_err++; $display("FAIL mid_tx_valid got %0b want 0", tx_valid); end
        if (busy !== 1'b0) begin n_err++; $display("FAIL mid_busy got %0b want 0", busy); end
        if (done !== 1'b0) begin n_err++; $display("FAIL mid_done got %0b want 0", done); end
        dyn_mode = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk);
        #1;
        set_static(32'h0900_0000);
        clear_log();
        issue(2'd1, 4'd9);
        wait_done(200, ok);
        n_vec += 2;
        if (!ok) begin n_err++; $display("FAIL post_timeout done never seen"); end
        if (rx_q.size() != 34) begin n_err++; $display("FAIL post_len got %0d want 34", rx_q.size()); end
        for (int i = 0; i < 34 && i < rx_q.size(); i++) begin
            n_vec++;
            if (rx_q[i] !== exp_byte(9, i)) begin n_err++; $display("FAIL post_byte%0d got %h want %h", i, rx_q[i], exp_byte(9, i)); end
        end
    endtask

    initial begin
        tx_ready = 1'b1;
        test_reset();
        test_dump_one();
        test_dump_all();
        test_backpressure();
        test_clear();
        test_reserved();
        test_latch_hold();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
